// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: ping-pong framebuffer controller; clears and renders into the back bank,
// scans out the front bank and swaps on the first vsync after frame_done.
module fb_swap_ctrl #(
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 6,
    parameter int PIX_BITS = 12,
    parameter logic [PIX_BITS-1:0] CLEAR_COLOR = 12'h000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         render_valid,
    output logic                         render_ready,
    input  logic [COL_BITS-1:0]          render_col,
    input  logic [ROW_BITS-1:0]          render_row,
    input  logic [PIX_BITS-1:0]          render_pix,
    input  logic                         frame_done,
    input  logic                         vsync,
    input  logic [COL_BITS-1:0]          disp_col,
    input  logic [ROW_BITS-1:0]          disp_row,
    output logic [PIX_BITS-1:0]          disp_pix,
    output logic [COL_BITS+ROW_BITS-1:0] b0_waddr,
    output logic [COL_BITS+ROW_BITS-1:0] b1_waddr,
    output logic [PIX_BITS-1:0]          b0_din,
    output logic [PIX_BITS-1:0]          b1_din,
    output logic [COL_BITS+ROW_BITS-1:0] b0_raddr,
    output logic [COL_BITS+ROW_BITS-1:0] b1_raddr,
    input  logic [PIX_BITS-1:0]          b0_dout,
    input  logic [PIX_BITS-1:0]          b1_dout,
    output logic                         front,
    output logic                         clearing,
    output logic [7:0]                   frame_count
);
    localparam int AW = COL_BITS + ROW_BITS;

    typedef enum logic [1:0] {CLEAR, RENDER, WAIT_SWAP} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]       clr_cnt;
    logic [AW-1:0]       wr_addr;
    logic [PIX_BITS-1:0] wr_data;
    logic                wr_en;
    logic                swap;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = (state == CLEAR)     ? (&clr_cnt   ? RENDER    : CLEAR)     :
                   (state == RENDER)    ? (frame_done ? WAIT_SWAP : RENDER)    :
                   (state == WAIT_SWAP) ? (vsync      ? CLEAR     : WAIT_SWAP) : CLEAR;
    end

    always_comb begin
        clearing     = state == CLEAR;
        render_ready = state == RENDER;
        swap         = (state == WAIT_SWAP) && vsync;
        wr_en        = clearing || (render_ready && render_valid);
        wr_addr      = clearing ? clr_cnt : {render_row, render_col};
        wr_data      = clearing ? CLEAR_COLOR : render_pix;
    end

    // Bank write registers hold when idle so the always-writing RAMs just rewrite the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            front       <= 1'b0;
            clr_cnt     <= '0;
            frame_count <= 8'd0;
            b0_waddr    <= '0;
            b1_waddr    <= '0;
            b0_din      <= CLEAR_COLOR;
            b1_din      <= CLEAR_COLOR;
        end else begin
            clr_cnt <= clearing ? clr_cnt + 1'b1 : '0;
            if (swap) begin
                front       <= ~front;
                frame_count <= frame_count + 8'd1;
            end
            if (wr_en && front) begin
                b0_waddr <= wr_addr;
                b0_din   <= wr_data;
            end
            if (wr_en && !front) begin
                b1_waddr <= wr_addr;
                b1_din   <= wr_data;
            end
        end
    end

    assign b0_raddr = {disp_row, disp_col};
    assign b1_raddr = {disp_row, disp_col};
    assign disp_pix = front ? b1_dout : b0_dout;
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl: scoreboarded bench for fb_swap_ctrl with two always-writing RAM models;
// bank write-port changes are matched against a queue of expected writes.
module tb_fb_swap_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        render_valid = 1'b0;
    logic        render_ready;
    logic [6:0]  render_col = '0;
    logic [5:0]  render_row = '0;
    logic [11:0] render_pix = '0;
    logic        frame_done = 1'b0;
    logic        vsync = 1'b0;
    logic [6:0]  disp_col = '0;
    logic [5:0]  disp_row = '0;
    logic [11:0] disp_pix;
    logic [12:0] b0_waddr, b1_waddr, b0_raddr, b1_raddr;
    logic [11:0] b0_din, b1_din, b0_dout, b1_dout;
    logic        front, clearing;
    logic [7:0]  frame_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        bank;
        logic [12:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t         q[$];
    logic [24:0] last_m[2];
    logic [24:0] last_d[2];

    fb_swap_ctrl dut (
        .clk(clk), .rst(rst),
        .render_valid(render_valid), .render_ready(render_ready),
        .render_col(render_col), .render_row(render_row), .render_pix(render_pix),
        .frame_done(frame_done), .vsync(vsync),
        .disp_col(disp_col), .disp_row(disp_row), .disp_pix(disp_pix),
        .b0_waddr(b0_waddr), .b1_waddr(b1_waddr), .b0_din(b0_din), .b1_din(b1_din),
        .b0_raddr(b0_raddr), .b1_raddr(b1_raddr), .b0_dout(b0_dout), .b1_dout(b1_dout),
        .front(front), .clearing(clearing), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    logic [11:0] mem0 [8192];
    logic [11:0] mem1 [8192];
    always @(posedge clk) begin
        mem0[b0_waddr] <= b0_din;
        mem1[b1_waddr] <= b1_din;
    end
    assign b0_dout = mem0[b0_raddr];
    assign b1_dout = mem1[b1_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Only writes that visibly change a bank's write port are queued.
    task automatic push_wr(input bit b, input int a, input logic [11:0] d);
        wr_t e;
        e.bank = b;
        e.addr = a[12:0];
        e.data = d;
        if ({e.addr, d} != last_m[b]) q.push_back(e);
        last_m[b] = {e.addr, d};
    endtask

    task automatic push_clear(input bit b);
        for (int i = 0; i < 8192; i++) push_wr(b, i, 12'h000);
    endtask

    task automatic mon_cmp(input bit b, input logic [24:0] act);
        wr_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected: bank=%0d addr=%0d data=%h, expected no write", b, act[24:12], act[11:0]);
        end else begin
            e = q.pop_front();
            if (e.bank !== b || {e.addr, e.data} !== act) begin
                failures++;
                $display("FAIL wr_order: got bank=%0d addr=%0d data=%h, expected bank=%0d addr=%0d data=%h",
                         b, act[24:12], act[11:0], e.bank, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_d[0] = {b0_waddr, b0_din};
            last_d[1] = {b1_waddr, b1_din};
        end else begin
            if ({b0_waddr, b0_din} != last_d[0]) mon_cmp(1'b0, {b0_waddr, b0_din});
            if ({b1_waddr, b1_din} != last_d[1]) mon_cmp(1'b1, {b1_waddr, b1_din});
            last_d[0] = {b0_waddr, b0_din};
            last_d[1] = {b1_waddr, b1_din};
        end
    end

    initial begin
        last_m[0] = '0;
        last_m[1] = '0;
        tick(2);
        chk("rst_front", front, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_ready", render_ready, 0);
        chk("rst_clearing", clearing, 1);
        chk("rst_b1_waddr", b1_waddr, 0);
        chk("rst_b0_din", b0_din, 12'h000);
        rst = 1'b0;
        push_clear(1'b1);
        tick(100);
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        tick(99);
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        chk("clr_stray_clearing", clearing, 1);
        tick(7990);
        chk("clr_end_ready", render_ready, 0);
        chk("clr_end_clearing", clearing, 1);
        chk("clr_end_b1_waddr", b1_waddr, 8190);
        tick(1);
        chk("render_ready", render_ready, 1);
        chk("render_clearing", clearing, 0);
        chk("stray_front", front, 0);
        chk("stray_frame_count", frame_count, 0);
        chk("render_b1_waddr_last", b1_waddr, 8191);

        render_valid = 1'b1; render_col = 7'd5; render_row = 6'd3; render_pix = 12'hABC;
        push_wr(1'b1, 389, 12'hABC);
        tick(1);
        render_valid = 1'b0;
        chk("wr_b1_waddr", b1_waddr, 389);
        chk("wr_b1_din", b1_din, 12'hABC);
        chk("wr_b0_waddr", b0_waddr, 0);
        tick(3);
        chk("idle_b1_waddr", b1_waddr, 389);
        chk("idle_b1_din", b1_din, 12'hABC);
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        chk("render_vsync_front", front, 0);
        chk("render_vsync_ready", render_ready, 1);
        render_valid = 1'b1; render_col = 7'd127; render_row = 6'd63; render_pix = 12'h123;
        push_wr(1'b1, 8191, 12'h123);
        tick(1);
        render_valid = 1'b0;
        chk("wr_corner_b1_waddr", b1_waddr, 8191);

        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        chk("wait_ready", render_ready, 0);
        render_valid = 1'b1; render_col = 7'd1; render_row = 6'd1; render_pix = 12'hFFF;
        tick(10);
        render_valid = 1'b0;
        chk("wait_ready_hold", render_ready, 0);
        chk("wait_front", front, 0);
        chk("wait_no_write", b1_waddr, 8191);
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        push_clear(1'b0);
        chk("swap_front", front, 1);
        chk("swap_frame_count", frame_count, 1);
        chk("swap_clearing", clearing, 1);
        disp_col = 7'd5; disp_row = 6'd3;
        #1;
        chk("swap_disp_abc", disp_pix, 12'hABC);
        disp_col = 7'd127; disp_row = 6'd63;
        #1;
        chk("swap_disp_corner", disp_pix, 12'h123);
        tick(50);
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        chk("clr_fd_ignored", clearing, 1);
        tick(8140);
        chk("clr0_end_clearing", clearing, 1);
        tick(1);
        chk("clr0_done_ready", render_ready, 1);
        chk("clr0_b0_waddr", b0_waddr, 8191);

        render_valid = 1'b1; render_col = 7'd9; render_row = 6'd0; render_pix = 12'h0F0;
        push_wr(1'b0, 9, 12'h0F0);
        tick(1);
        render_valid = 1'b0;
        chk("wr_b0_waddr9", b0_waddr, 9);
        chk("front_b1_held", b1_din, 12'h123);
        tick(1);
        chk("sb_drained", q.size(), 0);

        rst = 1'b1;
        tick(2);
        chk("mid_rst_front", front, 0);
        chk("mid_rst_frame_count", frame_count, 0);
        chk("mid_rst_ready", render_ready, 0);
        chk("mid_rst_clearing", clearing, 1);
        rst = 1'b0;
        q.delete();
        last_m[0] = '0;
        last_m[1] = '0;
        push_clear(1'b1);
        tick(5);
        chk("mid_rst_restart_addr", b1_waddr, 4);
        tick(8187);
        chk("mid_rst_clear_done", render_ready, 1);

        render_valid = 1'b1; render_col = 7'd2; render_row = 6'd1; render_pix = 12'h5A5;
        frame_done = 1'b1;
        vsync = 1'b1;
        push_wr(1'b1, 130, 12'h5A5);
        tick(1);
        render_valid = 1'b0;
        frame_done = 1'b0;
        vsync = 1'b0;
        chk("sim_ready", render_ready, 0);
        chk("sim_clearing", clearing, 0);
        chk("sim_front", front, 0);
        chk("sim_frame_count", frame_count, 0);
        chk("sim_b1_waddr", b1_waddr, 130);
        chk("sim_b1_din", b1_din, 12'h5A5);
        tick(2);
        chk("sim_front_hold", front, 0);
        disp_col = 7'd9; disp_row = 6'd0;
        #1;
        chk("stale_b0_disp", disp_pix, 12'h0F0);
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        push_clear(1'b0);
        chk("sim_swap_front", front, 1);
        chk("sim_swap_frame_count", frame_count, 1);
        disp_col = 7'd2; disp_row = 6'd1;
        #1;
        chk("sim_disp_5a5", disp_pix, 12'h5A5);
        tick(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
